// File: rtl/fetch_ifid_pkg.sv
// fetch_ifid_pkg: FSM state encoding, IF/ID entry layout and instruction field positions
package fetch_ifid_pkg;
  typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, DROP = 2'd2} state_t;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam int RS_MSB = 25;
  localparam int RT_MSB = 20;
  localparam int IMM_W = 16;
  localparam int JADDR_W = 26;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_t;
endpackage

// File: rtl/ifid_skid.sv
// ifid_skid: IF/ID register plus one-entry skid buffer with load/hold/flush (clk, rst, load, stall, flush, d -> valid, q)
module ifid_skid import fetch_ifid_pkg::*; #(
  parameter logic [31:0] NOP = NOP_WORD
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  stall,
  input  logic  flush,
  input  ifid_t d,
  output logic  valid,
  output ifid_t q
);
  ifid_t skid;
  logic skid_v;
  always_ff @(posedge clk)
    if (rst) begin
      valid <= 1'b0;
      q <= '{instr: NOP, pc4: 32'h0};
      skid <= '0;
      skid_v <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
      q.instr <= NOP;
      skid_v <= 1'b0;
    end else if (load && stall && valid) begin
      skid <= d;
      skid_v <= 1'b1;
    end else if (load) begin
      q <= d;
      valid <= 1'b1;
    end else if (!stall && skid_v) begin
      q <= skid;
      valid <= 1'b1;
      skid_v <= 1'b0;
    end else if (!stall) begin
      valid <= 1'b0;
      q.instr <= NOP;
    end
endmodule

// File: rtl/fetch_ifid.sv
// fetch_ifid: instruction fetch (req/ack) with PC, redirect/drop FSM and IF/ID register feeding decode
module fetch_ifid #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = fetch_ifid_pkg::NOP_WORD
) (
  input  logic        reloj,
  input  logic        reset,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIR_PC,
  output logic        IM_REQ,
  output logic [31:0] IM_ADDR,
  input  logic [31:0] IM_DATA,
  input  logic        IM_ACK,
  output logic        VALID_ID,
  output logic [31:0] INSTR_ID,
  output logic [31:0] PC4_ID,
  output logic [3:0]  PC_4,
  output logic [4:0]  DIR_A,
  output logic [4:0]  DIR_B,
  output logic [15:0] IMD,
  output logic [25:0] address
);
  import fetch_ifid_pkg::*;
  state_t state, state_nx;
  logic [31:0] pc, pc_nx, tgt, tgt_nx, redir, pc4;
  logic ack, pending, ld;
  ifid_t d, q;
  assign redir = REDIR_PC & ~32'd3;
  assign pc4 = pc + 32'd4;
  assign IM_REQ = !reset && state != HOLD;
  assign IM_ADDR = pc & ~32'd3;
  assign ack = IM_REQ && IM_ACK;
  assign pending = state != HOLD && !ack;
  assign ld = state == FETCH && ack && !REDIRECT;
  assign d = '{instr: IM_DATA, pc4: pc4};
  always_comb begin
    state_nx = state;
    pc_nx = pc;
    tgt_nx = tgt;
    if (REDIRECT) begin
      state_nx = pending ? DROP : FETCH;
      pc_nx = pending ? pc : redir;
      tgt_nx = redir;
    end else if (state == DROP) begin
      state_nx = ack ? FETCH : DROP;
      pc_nx = ack ? tgt : pc;
    end else if (state == FETCH && ack) begin
      state_nx = STALL && VALID_ID ? HOLD : FETCH;
      pc_nx = pc4;
    end else if (state == HOLD && !STALL) begin
      state_nx = FETCH;
    end
  end
  always_ff @(posedge reloj)
    if (reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      tgt <= RESET_PC;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      tgt <= tgt_nx;
    end
  ifid_skid #(.NOP(NOP_WORD)) u_skid (
    .clk(reloj),
    .rst(reset),
    .load(ld),
    .stall(STALL),
    .flush(REDIRECT),
    .d(d),
    .valid(VALID_ID),
    .q(q)
  );
  assign INSTR_ID = q.instr;
  assign PC4_ID = q.pc4;
  assign PC_4 = PC4_ID[31:28];
  assign DIR_A = INSTR_ID[RS_MSB -: 5];
  assign DIR_B = INSTR_ID[RT_MSB -: 5];
  assign IMD = INSTR_ID[IMM_W-1:0];
  assign address = INSTR_ID[JADDR_W-1:0];
endmodule
